conv3x3_window_gen: RTL and testbench

CONV3X3_WINDOW_GEN -- requirements
Module: conv3x3_window_gen

---
 rtl/conv3x3_window_gen.sv | 142 ++++++++++++++
 tb/tb_conv3x3_window_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_window_gen.sv
// -----------------------------------------------------------------------------
// conv3x3_window_gen
//   Turns a raster-order pixel stream into 3x3 sliding windows for a MAC array.
//   Two line buffers hold the previous two rows; a 3x3 register window shifts
//   left by one column on every accepted pixel. A window is offered only once
//   it lies fully inside the current frame (row >= 2 and col >= 2).
//
// Ports
//   clk         single clock, rising edge
//   arst_in     asynchronous active-high reset
//   clear       synchronous frame abort (priority over accept)
//   in_valid    input pixel valid
//   in_ready    block can accept a pixel this cycle
//   in_pixel    signed pixel, raster order
//   w0..w8      3x3 window taps, row-major, w0 = top-left, w8 = bottom-right
//   out_valid   window taps valid
//   out_ready   downstream accepts window
//   frame_done  one-cycle pulse after the last pixel of a frame is accepted
// -----------------------------------------------------------------------------
module conv3x3_window_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic                  clk,
  input  logic                  arst_in,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pixel,
  output logic [DATA_WIDTH-1:0] w0,
  output logic [DATA_WIDTH-1:0] w1,
  output logic [DATA_WIDTH-1:0] w2,
  output logic [DATA_WIDTH-1:0] w3,
  output logic [DATA_WIDTH-1:0] w4,
  output logic [DATA_WIDTH-1:0] w5,
  output logic [DATA_WIDTH-1:0] w6,
  output logic [DATA_WIDTH-1:0] w7,
  output logic [DATA_WIDTH-1:0] w8,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done
);

  localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
  localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2);

  // Stage p0: position of the incoming pixel, handshake
  logic [CW-1:0] col_p0;
  logic [RW-1:0] row_p0;
  logic          accept_p0;
  logic          qualify_p0;
  logic          last_p0;
  logic signed [DATA_WIDTH-1:0] pix_p0;

  // Stage p1: line buffers, window registers, output flags
  logic signed [DATA_WIDTH-1:0] lb0_p1 [IMG_WIDTH];
  logic signed [DATA_WIDTH-1:0] lb1_p1 [IMG_WIDTH];
  logic signed [DATA_WIDTH-1:0] win_p1 [3][3];
  logic                         vld_p1;
  logic                         fd_p1;

  assign pix_p0     = in_pixel;
  assign in_ready   = !vld_p1 || out_ready;
  assign accept_p0  = in_valid && in_ready;
  assign qualify_p0 = (row_p0 >= ROW_MIN) && (col_p0 >= COL_MIN);
  assign last_p0    = (row_p0 == ROW_LAST) && (col_p0 == COL_LAST);

  // Control: counters and output flags. clear wins over an accept in the
  // same cycle, so the pixel presented alongside clear is dropped.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      col_p0 <= '0;
      row_p0 <= '0;
      vld_p1 <= 1'b0;
      fd_p1  <= 1'b0;
    end else if (clear) begin
      col_p0 <= '0;
      row_p0 <= '0;
      vld_p1 <= 1'b0;
      fd_p1  <= 1'b0;
    end else if (accept_p0) begin
      if (col_p0 == COL_LAST) begin
        col_p0 <= '0;
        row_p0 <= (row_p0 == ROW_LAST) ? '0 : row_p0 + 1'b1;
      end else begin
        col_p0 <= col_p0 + 1'b1;
      end
      // An accept implies any pending window is being consumed now, so the
      // flag simply follows whether this pixel completes a full window.
      vld_p1 <= qualify_p0;
      fd_p1  <= last_p0;
    end else begin
      if (out_ready) vld_p1 <= 1'b0;
      fd_p1 <= 1'b0;
    end
  end

  // Data: line buffers and shifting window, updated only on a real accept.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      for (int i = 0; i < IMG_WIDTH; i++) begin
        lb0_p1[i] <= '0;
        lb1_p1[i] <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < 3; k++) begin
          win_p1[r][k] <= '0;
        end
      end
    end else if (accept_p0 && !clear) begin
      lb1_p1[col_p0] <= lb0_p1[col_p0];
      lb0_p1[col_p0] <= pix_p0;
      for (int r = 0; r < 3; r++) begin
        win_p1[r][0] <= win_p1[r][1];
        win_p1[r][1] <= win_p1[r][2];
      end
      win_p1[0][2] <= lb1_p1[col_p0];
      win_p1[1][2] <= lb0_p1[col_p0];
      win_p1[2][2] <= pix_p0;
    end
  end

  assign w0 = win_p1[0][0];
  assign w1 = win_p1[0][1];
  assign w2 = win_p1[0][2];
  assign w3 = win_p1[1][0];
  assign w4 = win_p1[1][1];
  assign w5 = win_p1[1][2];
  assign w6 = win_p1[2][0];
  assign w7 = win_p1[2][1];
  assign w8 = win_p1[2][2];

  assign out_valid  = vld_p1;
  assign frame_done = fd_p1;

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// -----------------------------------------------------------------------------
// tb_conv3x3_window_gen
//   Directed bench for conv3x3_window_gen at 4x4, 16-bit pixels. A frame-level
//   model (image array + pending window queue) predicts outputs every cycle;
//   consumed windows are also compared against hand-written literal windows.
// -----------------------------------------------------------------------------
module tb_conv3x3_window_gen;

  localparam int DW = 16;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          arst_in;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_pixel;
  logic [DW-1:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
  logic          out_valid;
  logic          out_ready;
  logic          frame_done;

  conv3x3_window_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .arst_in(arst_in), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7), .w8(w8),
    .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef logic [9*DW-1:0] win_t;

  win_t win_q[$];   // windows the model expects to be on the taps
  win_t got_q[$];   // windows consumed (handshake) during the current test
  int   fd_cnt;
  int   idx;        // raster index of next pixel within the frame
  logic exp_fd;
  int   img [H][W];
  win_t ref033 [4];
  win_t ref034b [4];

  function automatic win_t win9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {16'(a0), 16'(a1), 16'(a2), 16'(a3), 16'(a4), 16'(a5), 16'(a6), 16'(a7), 16'(a8)};
  endfunction

  function automatic win_t taps();
    return {w0, w1, w2, w3, w4, w5, w6, w7, w8};
  endfunction

  task automatic chk(input string nm, input win_t act, input win_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the frame model, sampled on the falling edge.
  always @(negedge clk) begin
    if (arst_in) begin
      chk("rst_out_valid", win_t'(out_valid), win_t'(1'b0));
      chk("rst_frame_done", win_t'(frame_done), win_t'(1'b0));
      chk("rst_in_ready", win_t'(in_ready), win_t'(1'b1));
      chk("rst_taps", taps(), '0);
      win_q.delete();
      idx = 0;
      exp_fd = 1'b0;
    end else begin
      logic nfd;
      chk("out_valid", win_t'(out_valid), win_t'(win_q.size() > 0));
      if (out_valid && win_q.size() > 0) chk("taps", taps(), win_q[0]);
      chk("frame_done", win_t'(frame_done), win_t'(exp_fd));
      chk("in_ready", win_t'(in_ready), win_t'((win_q.size() == 0) || out_ready));
      if (frame_done) fd_cnt++;
      nfd = 1'b0;
      if (clear) begin
        win_q.delete();
        idx = 0;
      end else begin
        if (out_valid && out_ready && win_q.size() > 0) begin
          got_q.push_back(taps());
          void'(win_q.pop_front());
        end
        if (in_valid && in_ready) begin
          int r, c;
          r = idx / W;
          c = idx % W;
          img[r][c] = int'(in_pixel);
          if (r >= 2 && c >= 2)
            win_q.push_back(win9(img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                                 img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                                 img[r][c-2],   img[r][c-1],   img[r][c]));
          if (idx == W*H - 1) nfd = 1'b1;
          idx = (idx + 1) % (W*H);
        end
      end
      exp_fd = nfd;
    end
  end

  task automatic send(input int v);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_pixel = 16'(v);
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: pixel %0d not accepted, needed accept within 100 cycles", v);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_test();
    got_q.delete();
    fd_cnt = 0;
  endtask

  task automatic check_ref033(input string nm);
    chk({nm, "_count"}, win_t'(got_q.size()), win_t'(4));
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) chk({nm, "_win"}, got_q[i], ref033[i]);
    chk({nm, "_fd"}, win_t'(fd_cnt), win_t'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ref033[0]  = win9(1, 2, 3, 5, 6, 7, 9, 10, 11);
    ref033[1]  = win9(2, 3, 4, 6, 7, 8, 10, 11, 12);
    ref033[2]  = win9(5, 6, 7, 9, 10, 11, 13, 14, 15);
    ref033[3]  = win9(6, 7, 8, 10, 11, 12, 14, 15, 16);
    ref034b[0] = win9(17, 18, 19, 21, 22, 23, 25, 26, 27);
    ref034b[1] = win9(18, 19, 20, 22, 23, 24, 26, 27, 28);
    ref034b[2] = win9(21, 22, 23, 25, 26, 27, 29, 30, 31);
    ref034b[3] = win9(22, 23, 24, 26, 27, 28, 30, 31, 32);
    idx = 0;
    exp_fd = 1'b0;
    fd_cnt = 0;

    arst_in   = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b1;
    idle(3);
    arst_in = 1'b0;
    idle(1);
    chk("after_reset_in_ready", win_t'(in_ready), win_t'(1'b1));

    // Full-throughput single frame
    begin_test();
    for (int p = 1; p <= 16; p++) send(p);
    idle(3);
    check_ref033("stream");

    // Two frames back-to-back
    begin_test();
    for (int p = 1; p <= 32; p++) send(p);
    idle(3);
    chk("b2b_count", win_t'(got_q.size()), win_t'(8));
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size())     chk("b2b_win_f1", got_q[i], ref033[i]);
      if (i + 4 < got_q.size()) chk("b2b_win_f2", got_q[i+4], ref034b[i]);
    end
    chk("b2b_fd", win_t'(fd_cnt), win_t'(2));

    // Downstream stall at the first window
    begin_test();
    out_ready = 1'b0;
    fork
      for (int p = 1; p <= 16; p++) send(p);
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("stall_seen", win_t'(out_valid), win_t'(1'b1));
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          chk("stall_in_ready", win_t'(in_ready), win_t'(1'b0));
          chk("stall_taps", taps(), ref033[0]);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(3);
    check_ref033("stall");

    // Random input bubbles
    begin_test();
    for (int p = 1; p <= 16; p++) begin
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      send(p);
    end
    idle(3);
    check_ref033("gaps");

    // Reset mid-frame, then restart
    begin_test();
    for (int p = 1; p <= 7; p++) send(p);
    arst_in = 1'b1;
    idle(2);
    arst_in = 1'b0;
    idle(1);
    begin_test();
    for (int p = 1; p <= 16; p++) send(p);
    idle(3);
    check_ref033("rst_restart");

    // Clear while pixel 9 is offered
    begin_test();
    for (int p = 1; p <= 8; p++) send(p);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_pixel = 16'(9);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clear_out_valid", win_t'(out_valid), win_t'(1'b0));
    chk("clear_frame_done", win_t'(frame_done), win_t'(1'b0));
    @(posedge clk);
    #1;
    begin_test();
    for (int p = 1; p <= 16; p++) send(p);
    idle(3);
    check_ref033("clear_restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
